// File: rtl/serial_subtractor_using_mux_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_subtractor_using_mux_pkg;

  // FSM state encodings; the fourth encoding is unused and falls back to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Default operand/result width (legal range 2..32).
  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_using_mux_pkg

// File: rtl/full_subtractor_using_mux.sv
// Combinational one-bit full subtractor built only from mux_2x1 cells.
//   d  = a ^ b ^ bin
//   bo = (~a & b) | (~(a ^ b) & bin)
// When a != b the borrow-out equals b; when a == b it passes bin through,
// so the borrow needs just one mux steered by a ^ b.
module full_subtractor_using_mux (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic b_n;     // ~b
  logic bin_n;   // ~bin
  logic a_x_b;   // a ^ b

  // Inverters: select between constant 1 and 0 using the signal itself.
  mux_2x1 u_inv_b   (.in0(1'b1), .in1(1'b0), .sel(b),   .y(b_n));
  mux_2x1 u_inv_bin (.in0(1'b1), .in1(1'b0), .sel(bin), .y(bin_n));

  // a ^ b: pass b when a is 0, ~b when a is 1.
  mux_2x1 u_xor_ab  (.in0(b),    .in1(b_n),  .sel(a),     .y(a_x_b));

  // Difference bit: (a ^ b) ^ bin.
  mux_2x1 u_xor_d   (.in0(bin),  .in1(bin_n), .sel(a_x_b), .y(d));

  // Borrow-out: bin when a == b, otherwise b.
  mux_2x1 u_borrow  (.in0(bin),  .in1(b),     .sel(a_x_b), .y(bo));

endmodule : full_subtractor_using_mux

// File: rtl/mux_2x1.sv
// Two-input, one-bit multiplexer: the only primitive the subtractor cell uses.
module mux_2x1 (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic y
);

  assign y = sel ? in1 : in0;

endmodule : mux_2x1

// File: rtl/serial_subtractor_using_mux.sv
// Bit-serial WIDTH-bit unsigned subtractor: diff = a - b - bin (mod 2^WIDTH)
// with borrow-out. One mux-built full-subtractor cell is reused every cycle,
// LSB first, with a registered borrow. Start/busy/done handshake.
module serial_subtractor_using_mux
  import serial_subtractor_using_mux_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q,   bout_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_shifted;

  // Single shared subtractor cell working on the current LSBs.
  full_subtractor_using_mux u_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // New difference bit enters from the MSB side so bit 0 lands at bit 0.
  assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

  // Next-state and datapath control for IDLE/RUN/DONE.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_shifted;
        borrow_d = cell_bo;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result and park the counter at zero so it
          // never runs past WIDTH-1.
          state_d = S_DONE;
          diff_d  = res_shifted;
          bout_d  = cell_bo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_DONE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule : serial_subtractor_using_mux

// File: tb/tb_serial_subtractor_using_mux.sv
// Self-checking bench for serial_subtractor_using_mux: WIDTH=8 directed and
// random operations plus an exhaustive WIDTH=4 sweep, all compared against a
// plain-arithmetic reference of a - b - bin.
module tb_serial_subtractor_using_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor_using_mux #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_using_mux #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] held8    = '0;
  logic [31:0] held4    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic, wrapped to w bits.
  task automatic ref_sub(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, output logic [31:0] d, output logic bo);
    longint r;
    longint m;
    m  = (longint'(1) << w) - 1;
    r  = longint'(av) - longint'(bv) - longint'(bi);
    bo = (r < 0);
    d  = 32'(r & m);
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic bi);
    if (w == 8) begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
    end else begin
      start4 = s; a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic bo, output logic [31:0] df);
    if (w == 8) begin
      bz = busy8; dn = done8; bo = bout8; df = 32'(diff8);
    end else begin
      bz = busy4; dn = done4; bo = bout4; df = 32'(diff4);
    end
  endtask

  // Present an operation for one edge, then scramble the operand inputs.
  task automatic accept(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi);
    drive(w, 1'b1, av, bv, bi);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // Called #1 after the accept edge. Checks busy/done on each of the w+1 busy
  // cycles, the held diff while running, the result in the done cycle, and
  // the following IDLE cycle.
  task automatic finish_op(input int w, input string tag, input logic [31:0] exp_d,
                           input logic exp_b, output int done_cyc);
    logic        bz, dn, bo;
    logic [31:0] df, held;
    held     = (w == 8) ? held8 : held4;
    done_cyc = -1;
    for (int i = 0; i <= w; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      sample(w, bz, dn, bo, df);
      check({tag, "_busy"}, 32'(bz), 32'd1);
      check({tag, "_done"}, 32'(dn), 32'(i == w));
      if (dn) done_cyc = cyc;
      if (i == w) begin
        check({tag, "_diff"}, df, exp_d);
        check({tag, "_bout"}, 32'(bo), 32'(exp_b));
      end else begin
        check({tag, "_hold"}, df, held);
      end
    end
    if (w == 8) held8 = exp_d; else held4 = exp_d;
    @(posedge clk); #1;
    sample(w, bz, dn, bo, df);
    check({tag, "_idle_busy"}, 32'(bz), 32'd0);
    check({tag, "_idle_done"}, 32'(dn), 32'd0);
    check({tag, "_idle_diff"}, df, exp_d);
  endtask

  task automatic run_op(input int w, input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic bi,
                        input logic [31:0] exp_d, input logic exp_b);
    int t;
    accept(w, av, bv, bi);
    finish_op(w, tag, exp_d, exp_b, t);
  endtask

  initial begin
    logic [31:0] av, bv, ed;
    logic        bi, eb;
    int          t1, t2;

    rst = 1'b1;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(4, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);
    check("rst_bout8", 32'(bout8), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_diff4", 32'(diff4), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    run_op(8, "t1",  32'h5A, 32'h21, 1'b0, 32'h39, 1'b0);
    run_op(8, "t2a", 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1);
    run_op(8, "t2b", 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1);
    run_op(8, "t3a", 32'h80, 32'h7F, 1'b1, 32'h00, 1'b0);
    run_op(8, "t3b", 32'h10, 32'h10, 1'b1, 32'hFF, 1'b1);

    // Start held high with different operands throughout RUN/DONE.
    drive(8, 1'b1, 32'h33, 32'h11, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b1, 32'h07, 32'h09, 1'b1);
    finish_op(8, "t4a", 32'h22, 1'b0, t1);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
    finish_op(8, "t4b", 32'hFD, 1'b1, t2);
    check("t4_gap", 32'(t2 - t1), 32'd10);

    // Reset while the operation is on bit 3.
    accept(8, 32'h00, 32'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held8 = '0;
    held4 = '0;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_diff", 32'(diff8), 32'd0);
    check("t5_bout", 32'(bout8), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t5_no_done", 32'(done8), 32'd0);
      check("t5_no_busy", 32'(busy8), 32'd0);
    end
    run_op(8, "t5_fresh", 32'hC3, 32'h3C, 1'b0, 32'h87, 1'b0);

    // Random WIDTH=8 operations against the reference.
    repeat (40) begin
      av = $urandom & 32'hFF;
      bv = $urandom & 32'hFF;
      bi = 1'($urandom_range(0, 1));
      ref_sub(8, av, bv, bi, ed, eb);
      run_op(8, "rnd8", av, bv, bi, ed, eb);
    end

    // Exhaustive WIDTH=4 sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ref_sub(4, 32'(ia), 32'(ib), 1'(ic), ed, eb);
          run_op(4, "sweep4", 32'(ia), 32'(ib), 1'(ic), ed, eb);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor_using_mux
